// File: rtl/mem_arbiter.sv
// Word-level arbiter between dcache and icache onto a single-port RAM.
// Dcache has priority; a saturating starvation counter forces periodic fetches.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int CNT_W        = 4
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic        dwait,
  output logic [31:0] dload,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic        iwait,
  output logic [31:0] iload,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic [1:0]  ramstate
);

  typedef enum logic [1:0] {IDLE, DGRANT, IGRANT} state_t;
  localparam logic [1:0]       ACCESS = 2'd2;
  localparam logic [CNT_W-1:0] LIMIT  = CNT_W'(STARVE_LIMIT);

  state_t           r_state;
  logic [CNT_W-1:0] r_starve_cnt;

  logic w_d_req, w_starved, w_sel_d, w_sel_i, w_done;

  assign w_d_req   = dREN | dWEN;
  assign w_starved = (STARVE_LIMIT != 0) && (r_starve_cnt == LIMIT);

  // Selection is gated by nRST so outputs fall to reset values immediately.
  always_comb begin
    w_sel_d = 1'b0;
    w_sel_i = 1'b0;
    if (nRST) begin
      case (r_state)
        IDLE: begin
          w_sel_i = iREN && (!w_d_req || w_starved);
          w_sel_d = !w_sel_i && w_d_req;
        end
        DGRANT:  w_sel_d = w_d_req;
        IGRANT:  w_sel_i = iREN;
        default: ;
      endcase
    end
  end

  always_comb begin
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = 32'h0;
    ramstore = 32'h0;
    if (w_sel_d) begin
      ramaddr  = daddr;
      ramstore = dstore;
      ramWEN   = dWEN;
      ramREN   = !dWEN;
    end else if (w_sel_i) begin
      ramaddr = iaddr;
      ramREN  = 1'b1;
    end
  end

  assign w_done = (w_sel_d | w_sel_i) && (ramstate == ACCESS);
  assign dwait  = !(w_sel_d && w_done);
  assign iwait  = !(w_sel_i && w_done);
  assign dload  = ramload;
  assign iload  = ramload;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      r_state      <= IDLE;
      r_starve_cnt <= '0;
    end else begin
      // Every completed word returns to IDLE so each word is re-arbitrated.
      if (w_done)       r_state <= IDLE;
      else if (w_sel_d) r_state <= DGRANT;
      else if (w_sel_i) r_state <= IGRANT;
      else              r_state <= IDLE;

      if (!iREN || (w_sel_i && w_done))
        r_starve_cnt <= '0;
      else if (w_sel_d && w_done && r_starve_cnt < LIMIT)
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with STARVE_LIMIT=2; inputs change on the
// falling edge and outputs are checked 1ns later.
module tb_mem_arbiter;
  logic        CLK = 1'b0, nRST = 1'b0;
  logic        dREN = 0, dWEN = 0, iREN = 0;
  logic [31:0] daddr = 0, dstore = 0, iaddr = 0, ramload = 0;
  logic [1:0]  ramstate = 2'd0;
  logic        dwait, iwait, ramREN, ramWEN;
  logic [31:0] dload, iload, ramaddr, ramstore;
  int total = 0, bad = 0;

  localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

  mem_arbiter #(.STARVE_LIMIT(2), .CNT_W(4)) dut (
    .CLK(CLK), .nRST(nRST),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dwait(dwait), .dload(dload),
    .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramstate(ramstate)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  initial begin
    logic exp_d [6];
    logic exp_i [6];
    exp_d = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    exp_i = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with requests present
    dREN = 1; iREN = 1; daddr = 32'h40; iaddr = 32'h44; ramstate = ACCESS;
    step(); #1;
    chk("rst_dwait", dwait, 1); chk("rst_iwait", iwait, 1);
    chk("rst_ren", ramREN, 0); chk("rst_wen", ramWEN, 0);
    chk("rst_addr", ramaddr, 0);
    dREN = 0; iREN = 0; ramstate = FREE;
    step(); nRST = 1;

    // Single dcache read: two BUSY then ACCESS
    step(); dREN = 1; daddr = 32'h40; ramstate = BUSY; #1;
    chk("rd1_ren", ramREN, 1); chk("rd1_addr", ramaddr, 32'h40); chk("rd1_dwait", dwait, 1);
    step(); #1;
    chk("rd2_ren", ramREN, 1); chk("rd2_addr", ramaddr, 32'h40); chk("rd2_dwait", dwait, 1);
    step(); ramstate = ACCESS; ramload = 32'hCAFEF00D; #1;
    chk("rd3_ren", ramREN, 1); chk("rd3_addr", ramaddr, 32'h40);
    chk("rd3_dwait", dwait, 0); chk("rd3_dload", dload, 32'hCAFEF00D);
    chk("rd3_iwait", iwait, 1);
    step(); dREN = 0; ramstate = FREE; #1;
    chk("rd4_dwait", dwait, 1); chk("rd4_ren", ramREN, 0);

    // Simultaneous write (with dREN also high) and fetch
    step(); dREN = 1; dWEN = 1; daddr = 32'h80; dstore = 32'h12345678;
    iREN = 1; iaddr = 32'h0; ramstate = ACCESS; #1;
    chk("sim_wen", ramWEN, 1); chk("sim_ren", ramREN, 0);
    chk("sim_addr", ramaddr, 32'h80); chk("sim_store", ramstore, 32'h12345678);
    chk("sim_dwait", dwait, 0); chk("sim_iwait", iwait, 1);
    step(); dREN = 0; dWEN = 0; #1;
    chk("sim_i_addr", ramaddr, 32'h0); chk("sim_i_ren", ramREN, 1);
    chk("sim_i_store", ramstore, 0); chk("sim_i_iwait", iwait, 0);
    chk("sim_i_dwait", dwait, 1);
    step(); iREN = 0; ramstate = FREE;

    // No preemption of an icache grant; ERROR counts as not complete
    step(); iREN = 1; iaddr = 32'h100; ramstate = BUSY; #1;
    chk("np_addr0", ramaddr, 32'h100);
    step(); dREN = 1; daddr = 32'h200; ramstate = ERROR; #1;
    chk("np_addr1", ramaddr, 32'h100); chk("np_iwait1", iwait, 1); chk("np_dwait1", dwait, 1);
    step(); ramstate = ACCESS; #1;
    chk("np_addr2", ramaddr, 32'h100); chk("np_iwait2", iwait, 0); chk("np_dwait2", dwait, 1);
    step(); iREN = 0; #1;
    chk("np_daddr", ramaddr, 32'h200); chk("np_dwait3", dwait, 0);
    step(); dREN = 0; ramstate = FREE;

    // Starvation: expect D,D,I,D,D,I
    step(); dREN = 1; daddr = 32'h300; iREN = 1; iaddr = 32'h400; ramstate = ACCESS;
    for (int k = 0; k < 6; k++) begin
      #1;
      chk($sformatf("stv%0d_dwait", k), dwait, exp_d[k]);
      chk($sformatf("stv%0d_iwait", k), iwait, exp_i[k]);
      step();
    end
    dREN = 0; iREN = 0; ramstate = FREE;

    // Abort: dcache drops request while granted, even with ACCESS present
    step(); dREN = 1; daddr = 32'h500; ramstate = BUSY; #1;
    chk("ab_ren0", ramREN, 1);
    step(); dREN = 0; ramstate = ACCESS; #1;
    chk("ab_ren1", ramREN, 0); chk("ab_dwait", dwait, 1);
    step(); iREN = 1; iaddr = 32'h600; ramstate = BUSY; #1;
    chk("ab_idle_addr", ramaddr, 32'h600);
    step(); iREN = 0; ramstate = FREE;

    // Reset mid-access forces outputs immediately
    step(); dREN = 1; daddr = 32'h700; ramstate = BUSY; #1;
    chk("mr_ren0", ramREN, 1);
    #1 nRST = 0; #1;
    chk("mr_ren1", ramREN, 0); chk("mr_addr", ramaddr, 0); chk("mr_dwait", dwait, 1);
    dREN = 0;
    step(); nRST = 1;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Responder end of the cache/memory control interface.
- Accepts word requests from the data cache (dREN/dWEN/daddr/dstore) and the instruction cache (iREN/iaddr), arbitrates them onto the single-port RAM, and returns dwait/dload and iwait/iload.
- Data cache has priority; a starvation counter guarantees instruction-fetch progress.
- Sits between both caches and the RAM model at the top of the single-core memory subsystem.

Parameters:
- STARVE_LIMIT, 4: consecutive data-side completions while iREN is pending before the icache is forced to win. 0 = strict data priority.
- CNT_W, 4: width of the starvation counter. Must hold STARVE_LIMIT.

Ports:
- CLK  in  1  system clock
- nRST  in  1  asynchronous active-low reset
- dREN  in  1  dcache read request
- dWEN  in  1  dcache write request
- daddr  in  32  dcache word address
- dstore  in  32  dcache write data
- dwait  out  1  low for exactly the cycle the dcache access completes
- dload  out  32  read data to dcache
- iREN  in  1  icache read request
- iaddr  in  32  icache word address
- iwait  out  1  low for exactly the cycle the icache access completes
- iload  out  32  read data to icache
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3

Behaviour:
- Reset (async, nRST low):
  - state=IDLE, owner=none, starve_cnt=0.
  - dwait=iwait=1, ramREN=ramWEN=0, ramaddr=0, ramstore=0.
- States:
  - IDLE: no access outstanding.
  - DGRANT: dcache owns the RAM.
  - IGRANT: icache owns the RAM.
- IDLE winner selection (combinational, same cycle):
  - icache wins if iREN and (no dcache request, or STARVE_LIMIT!=0 and starve_cnt==STARVE_LIMIT).
  - Otherwise the dcache wins if dREN|dWEN.
  - No request: RAM enables stay 0.
- RAM drive:
  - In IDLE, RAM outputs are driven from the winner in the same cycle.
  - In DGRANT/IGRANT, RAM outputs are driven from the owner.
  - dcache: ramaddr=daddr, ramstore=dstore. If dWEN, then ramWEN=1 and ramREN=0 (write wins if both are asserted). Else ramREN=1.
  - icache: ramaddr=iaddr, ramREN=1, ramWEN=0, ramstore=0.
- Completion:
  - Occurs when the RAM is driven and ramstate==ACCESS.
  - The active requester's wait goes 0 for that cycle only. All other waits stay 1.
  - Next state after completion is IDLE, so re-arbitration happens on every word (dcache two-word bursts may interleave with fetches).
- Grant holding:
  - IDLE with a winner but no ACCESS: go to DGRANT/IGRANT and hold the owner until ACCESS.
  - A later request from the other side cannot preempt.
  - Owner drops its request while granted: RAM enables deassert the same cycle and the next state is IDLE. No completion is signalled.
- ramstate BUSY/FREE/ERROR: treated as not complete; waits stay 1 and the state is held. ERROR is never reported upward.
- Data paths: dload=ramload and iload=ramload at all times, valid only while the corresponding wait is 0.
- Starvation counter (registered):
  - Increments (saturating at STARVE_LIMIT) on each dcache completion while iREN=1.
  - Clears on icache completion or any cycle with iREN=0.
  - Unchanged otherwise.
- Address changing mid-grant: the new address passes straight through to the RAM; the RAM model handles the restart.
- Reset asserted mid-access: the access is abandoned and outputs go to reset values immediately.

Test Plan:
- Reset: hold nRST=0 with dREN=iREN=1 -> dwait=iwait=1, ramREN=ramWEN=0, ramaddr=0.
- Single dcache read:
  - Stimulus: daddr=0x40, RAM returns ACCESS after 2 BUSY cycles with ramload=0xCAFEF00D.
  - Required: ramREN=1 with ramaddr=0x40 for 3 cycles, dwait=0 only on the third cycle, dload=0xCAFEF00D, iwait stays 1.
- Simultaneous requests:
  - Stimulus: dWEN daddr=0x80 dstore=0x12345678 and iREN iaddr=0x0, RAM 1-cycle ACCESS.
  - Required: the write is served first (ramWEN=1, ramaddr=0x80), then the fetch in the next cycle (ramaddr=0x0, iwait=0).
- No preemption:
  - Stimulus: icache granted with RAM BUSY; dREN rises.
  - Required: ramaddr stays at iaddr until ACCESS; the dcache is served on the following cycles.
- Starvation, STARVE_LIMIT=2:
  - Stimulus: dREN continuously high and iREN high, RAM ACCESS every cycle.
  - Required: completion pattern D,D,I,D,D,I.
- Abort:
  - Stimulus: dcache granted, RAM BUSY; dREN drops.
  - Required: ramREN=0 the same cycle, state IDLE next cycle, dwait never 0.
